us_flow_scheduler: RTL and testbench
====================================

// Module: us_flow_scheduler
// PURPOSE
//  Period-driven scheduler that drains CH_NUM per-channel upstream cache FIFOs into one 128-bit flow.
//  Each period_pulse_i: snapshots every channel's cache count, then visits channels 0..CH_NUM-1 in order.
//  For each visited channel it reads min(snapshot, MAX_BURST) words under prog_full backpressure.
//  Sits between the upstream channel caches and the aggregate flow FIFO feeding the uplink framer.
// PARAMETERS
//  CH_NUM     104  number of channel FIFOs
//  DATA_W     128  FIFO / flow word width
//  CNT_W      12   cache-count width per channel
//  MAX_BURST  256  max words drained per channel per period (<= 2**CNT_W)
//  CH_W       $clog2(CH_NUM)  channel-id width (localparam)
// PORTS
//  sys_clk_i          in   1              single clock
//  rst_i              in   1              reset, synchronous, active-high
//  period_pulse_i     in   1              1-cycle period tick (25 ms)
//  ch_rd_en_o         out  CH_NUM         one-hot FIFO read enable (standard FIFO, read latency 1)
//  ch_dout_i          in   CH_NUM*DATA_W  channel i data at [i*DATA_W +: DATA_W]
//  ch_empty_i         in   CH_NUM         FIFO empty flags
//  ch_cache_count_i   in   CH_NUM*CNT_W   FIFO data counts, channel i at [i*CNT_W +: CNT_W]
//  flow_prog_full_i   in   1              downstream prog_full; no new rd_en while high
//  flow_vld_o         out  1              flow word valid (registered)
//  flow_data_o        out  DATA_W         flow word (registered)
//  flow_ch_id_o       out  CH_W           source channel of flow word
//  busy_o             out  1              high in any state other than IDLE
//  overrun_o          out  1              1-cycle pulse: period_pulse_i arrived while busy
// BEHAVIOUR
//  Reset: state=IDLE; ch_rd_en_o=0, flow_vld_o=0, flow_data_o=0, flow_ch_id_o=0, busy_o=0, overrun_o=0, snapshots=0.
//  Reset mid-burst: abandons the burst immediately; in-flight reads are discarded, no flow_vld_o after reset.
//  FSM: IDLE -(period_pulse_i)-> SNAP -> SELECT -> [HDR] -> DRAIN -> FLUSH -> SELECT ... -> IDLE.
//  SNAP: one cycle; latch all CH_NUM counts; ch_idx=0.
//  SELECT: one channel per cycle.
//   - Skip: snapshot==0 -> ch_idx++.
//   - Otherwise: remaining=min(snap,MAX_BURST), then go to DRAIN (or HDR).
//   - After ch_idx==CH_NUM-1 is finished or skipped -> IDLE, with no wrap to 0.
//  DRAIN: ch_rd_en_o[ch_idx]=1 iff remaining>0 && !ch_empty_i[ch_idx] && !flow_prog_full_i; remaining-- per read.
//   - Empty or prog_full only stalls; it never skips words. remaining==0 -> FLUSH.
//  FLUSH: wait 2 cycles for pipeline drain, then ch_idx++ -> SELECT.
//  Latency: rd_en at cycle T -> dout sampled T+1 -> flow_vld_o/flow_data_o/flow_ch_id_o at T+2.
//   - Exactly one flow word per rd_en; words of a channel are contiguous and in FIFO order.
//  Downstream must absorb at least 2 words after prog_full asserts; the scheduler never drops data.
//  period_pulse_i outside IDLE: ignored; overrun_o pulses the next cycle. Words arriving after the snapshot wait for the next period.
//  Simultaneous rst_i and period_pulse_i: reset wins.
//  All counters saturate-free by construction: remaining is CNT_W+1 bits; ch_idx is CH_W bits.
// CONFIGURATION
//  US_SCHED_HEADER_EN defined: HDR state (1 cycle, waits while flow_prog_full_i) emits one header word before each non-empty channel burst.
//   - Header = {HDR_MAGIC[15:0], ch_idx zero-extended to 16b, burst_len zero-extended to 16b, 80'h0}, flow_ch_id_o=ch_idx.
//   - Header appears on flow_vld_o 2 cycles after HDR entry, in order with the data.
//  Not defined: no HDR state; the flow carries data words only.
// STRUCTURE
//  us_sched_pkg: state enum (IDLE,SNAP,SELECT,HDR,DRAIN,FLUSH), HDR_MAGIC=16'hA55A, header field offsets.
//  Sub-module us_sched_rd_pipe: 2-stage rd_en/ch_id delay plus data mux (DATA_W x CH_NUM).
//   - Registers flow_* outputs; the only wide-datapath logic.
//  Top: FSM, snapshot array, remaining/ch_idx counters.
// TESTING
//  1 Counts ch0=3, ch5=2, others 0; pulse -> 5 words: ch0 x3 then ch5 x2, ids 0,0,0,5,5; busy_o drops after ch103 is skipped.
//  2 ch7 count=300, MAX_BURST=256 -> exactly 256 words from ch7; 44 remain in the FIFO for the next period.
//  3 prog_full high for 10 cycles mid-burst of ch2 (count 8) -> rd_en gaps; total 8 words in order, no loss/duplication.
//  4 period_pulse_i re-asserted during DRAIN -> overrun_o pulses once; the current sweep is unaffected; no second sweep.
//  5 rst_i asserted at 3rd word of a 10-word burst -> all outputs 0 the next cycle; no flow_vld_o until the next pulse.
//  6 US_SCHED_HEADER_EN, ch1 count=4 -> header {16'hA55A,16'd1,16'd4,80'h0} followed by 4 data words, all id 1.

Source files
------------

// File: rtl/us_sched_pkg.sv
// Shared types and constants for the upstream flow scheduler.
// Contents: FSM state enum, header magic and field offsets, header builder.
// Optional build macro US_SCHED_HEADER_EN adds the per-burst header word.
package us_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SNAP,
      SELECT,
      HDR,
      DRAIN,
      FLUSH
   } sched_state_e;

   localparam logic [15:0] HDR_MAGIC     = 16'hA55A;
   localparam int unsigned HDR_W         = 128;
   localparam int unsigned HDR_FIELD_W   = 16;
   localparam int unsigned HDR_MAGIC_LSB = 112;
   localparam int unsigned HDR_CH_LSB    = 96;
   localparam int unsigned HDR_LEN_LSB   = 80;

   // Header word: magic, channel id, burst length, zero padding below.
   function automatic logic [HDR_W-1:0] make_header(input logic [HDR_FIELD_W-1:0] ch,
                                                    input logic [HDR_FIELD_W-1:0] len);
      logic [HDR_W-1:0] w;
      w = '0;
      w[HDR_MAGIC_LSB +: HDR_FIELD_W] = HDR_MAGIC;
      w[HDR_CH_LSB    +: HDR_FIELD_W] = ch;
      w[HDR_LEN_LSB   +: HDR_FIELD_W] = len;
      return w;
   endfunction

endpackage

// File: rtl/us_sched_rd_pipe.sv
// Read-return pipeline: delays read strobe and channel id by one cycle to
// line up with FIFO read data, then muxes the selected channel's word into
// the registered flow outputs.
// Ports: sys_clk_i, rst_i, rd_vld/ch_id (issue stage), ch_dout (all FIFO
// outputs), flow_vld/flow_data/flow_ch_id (registered flow word).
// With US_SCHED_HEADER_EN: hdr_vld/burst_len inject a header word in order.
module us_sched_rd_pipe
   import us_sched_pkg::*;
#(
   parameter int unsigned CH_NUM = 104,
   parameter int unsigned DATA_W = 128,
   parameter int unsigned CNT_W  = 12,
   parameter int unsigned CH_W   = 7
) (
   input  logic                     sys_clk_i,
   input  logic                     rst_i,
   input  logic                     rd_vld,
`ifdef US_SCHED_HEADER_EN
   input  logic                     hdr_vld,
   input  logic [CNT_W:0]           burst_len,
`endif
   input  logic [CH_W-1:0]          ch_id,
   input  logic [CH_NUM*DATA_W-1:0] ch_dout,
   output logic                     flow_vld,
   output logic [DATA_W-1:0]        flow_data,
   output logic [CH_W-1:0]          flow_ch_id
);

   logic            s1_vld;
   logic [CH_W-1:0] s1_ch;
   logic [DATA_W-1:0] word_c;
`ifdef US_SCHED_HEADER_EN
   logic            s1_hdr;
   logic [CNT_W:0]  s1_len;
`endif

   // Select the word of the channel read last cycle (or the header).
   always_comb begin
      word_c = '0;
      for (int i = 0; i < int'(CH_NUM); i++) begin
         if (s1_ch == CH_W'(i)) word_c = ch_dout[i*DATA_W +: DATA_W];
      end
`ifdef US_SCHED_HEADER_EN
      if (s1_hdr) word_c = DATA_W'(make_header(HDR_FIELD_W'(s1_ch), HDR_FIELD_W'(s1_len)));
`endif
   end

   // Stage 1 aligns with FIFO data; stage 2 registers the flow word.
   always_ff @(posedge sys_clk_i) begin
      if (rst_i) begin
         s1_vld     <= 1'b0;
         s1_ch      <= '0;
         flow_vld   <= 1'b0;
         flow_data  <= '0;
         flow_ch_id <= '0;
`ifdef US_SCHED_HEADER_EN
         s1_hdr     <= 1'b0;
         s1_len     <= '0;
`endif
      end else begin
`ifdef US_SCHED_HEADER_EN
         s1_vld     <= rd_vld | hdr_vld;
         s1_hdr     <= hdr_vld;
         s1_len     <= burst_len;
`else
         s1_vld     <= rd_vld;
`endif
         s1_ch      <= ch_id;
         flow_vld   <= s1_vld;
         if (s1_vld) begin
            flow_data  <= word_c;
            flow_ch_id <= s1_ch;
         end
      end
   end

endmodule

// File: rtl/us_flow_scheduler.sv
// Period-driven scheduler draining CH_NUM channel FIFOs into one flow.
// Each period tick snapshots all cache counts, then visits channels in
// order and reads min(snapshot, MAX_BURST) words from each, stalling on
// empty or downstream prog_full.
// Ports: sys_clk_i, rst_i (sync, active-high), period_pulse_i, channel FIFO
// side (ch_rd_en_o, ch_dout_i, ch_empty_i, ch_cache_count_i), flow side
// (flow_prog_full_i, flow_vld_o, flow_data_o, flow_ch_id_o), busy_o, overrun_o.
// Build macro US_SCHED_HEADER_EN: emit a header word before each burst.
module us_flow_scheduler
   import us_sched_pkg::*;
#(
   parameter int unsigned CH_NUM    = 104,
   parameter int unsigned DATA_W    = 128,
   parameter int unsigned CNT_W     = 12,
   parameter int unsigned MAX_BURST = 256,
   localparam int unsigned CH_W     = $clog2(CH_NUM)
) (
   input  logic                     sys_clk_i,
   input  logic                     rst_i,
   input  logic                     period_pulse_i,
   output logic [CH_NUM-1:0]        ch_rd_en_o,
   input  logic [CH_NUM*DATA_W-1:0] ch_dout_i,
   input  logic [CH_NUM-1:0]        ch_empty_i,
   input  logic [CH_NUM*CNT_W-1:0]  ch_cache_count_i,
   input  logic                     flow_prog_full_i,
   output logic                     flow_vld_o,
   output logic [DATA_W-1:0]        flow_data_o,
   output logic [CH_W-1:0]          flow_ch_id_o,
   output logic                     busy_o,
   output logic                     overrun_o
);

   localparam int unsigned     REM_W     = CNT_W + 1;
   localparam logic [REM_W-1:0] BURST_MAX = REM_W'(MAX_BURST);
   localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(CH_NUM - 1);

   sched_state_e      state_q, state_d;
   logic [CNT_W-1:0]  snap_q [CH_NUM];
   logic [CH_W-1:0]   ch_idx_q, ch_idx_d;
   logic [REM_W-1:0]  rem_q, rem_d;
   logic              flush_q, flush_d;
   logic              busy_q, overrun_q;
   logic              rd_go_c;
   logic [REM_W-1:0]  cur_snap_c;
   logic [REM_W-1:0]  cur_burst_c;
`ifdef US_SCHED_HEADER_EN
   logic              hdr_go_c;
`endif

   assign cur_snap_c  = REM_W'(snap_q[ch_idx_q]);
   assign cur_burst_c = (cur_snap_c > BURST_MAX) ? BURST_MAX : cur_snap_c;

   // Next-state and issue logic.
   always_comb begin
      state_d  = state_q;
      ch_idx_d = ch_idx_q;
      rem_d    = rem_q;
      flush_d  = flush_q;
      rd_go_c  = 1'b0;
`ifdef US_SCHED_HEADER_EN
      hdr_go_c = 1'b0;
`endif
      case (state_q)
         IDLE: if (period_pulse_i) state_d = SNAP;
         SNAP: begin
            ch_idx_d = '0;
            state_d  = SELECT;
         end
         SELECT: begin
            if (cur_snap_c == '0) begin
               if (ch_idx_q == LAST_CH) state_d = IDLE;
               else ch_idx_d = ch_idx_q + CH_W'(1);
            end else begin
               rem_d = cur_burst_c;
`ifdef US_SCHED_HEADER_EN
               state_d = HDR;
`else
               state_d = DRAIN;
`endif
            end
         end
`ifdef US_SCHED_HEADER_EN
         HDR: begin
            if (!flow_prog_full_i) begin
               hdr_go_c = 1'b1;
               state_d  = DRAIN;
            end
         end
`endif
         DRAIN: begin
            if (rem_q == '0) begin
               flush_d = 1'b0;
               state_d = FLUSH;
            end else if (!ch_empty_i[ch_idx_q] && !flow_prog_full_i) begin
               rd_go_c = 1'b1;
               rem_d   = rem_q - REM_W'(1);
            end
         end
         FLUSH: begin
            // Two cycles so the last read leaves the pipe before moving on.
            if (flush_q) begin
               if (ch_idx_q == LAST_CH) state_d = IDLE;
               else begin
                  ch_idx_d = ch_idx_q + CH_W'(1);
                  state_d  = SELECT;
               end
            end else begin
               flush_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counters, snapshot array and status flags.
   always_ff @(posedge sys_clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         ch_idx_q  <= '0;
         rem_q     <= '0;
         flush_q   <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
         for (int i = 0; i < int'(CH_NUM); i++) snap_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         ch_idx_q  <= ch_idx_d;
         rem_q     <= rem_d;
         flush_q   <= flush_d;
         busy_q    <= (state_d != IDLE);
         overrun_q <= period_pulse_i && (state_q != IDLE);
         if (state_q == SNAP) begin
            for (int i = 0; i < int'(CH_NUM); i++) snap_q[i] <= ch_cache_count_i[i*CNT_W +: CNT_W];
         end
      end
   end

   // Read enable must react to empty/prog_full in the same cycle, so it is
   // decoded from registered state; gated by reset so no word is popped then.
   assign ch_rd_en_o = (rd_go_c && !rst_i) ? (CH_NUM'(1) << ch_idx_q) : '0;
   assign busy_o     = busy_q;
   assign overrun_o  = overrun_q;

   us_sched_rd_pipe #(
      .CH_NUM (CH_NUM),
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W),
      .CH_W   (CH_W)
   ) u_rd_pipe (
      .sys_clk_i  (sys_clk_i),
      .rst_i      (rst_i),
      .rd_vld     (rd_go_c && !rst_i),
`ifdef US_SCHED_HEADER_EN
      .hdr_vld    (hdr_go_c && !rst_i),
      .burst_len  (rem_q),
`endif
      .ch_id      (ch_idx_q),
      .ch_dout    (ch_dout_i),
      .flow_vld   (flow_vld_o),
      .flow_data  (flow_data_o),
      .flow_ch_id (flow_ch_id_o)
   );

endmodule

// File: tb/tb_us_flow_scheduler.sv
// Scoreboard bench for us_flow_scheduler: queue-based channel FIFO models,
// a sweep-level reference model and a decoupled flow-word monitor.
module tb_us_flow_scheduler;

   localparam int CH_NUM    = 104;
   localparam int DATA_W    = 128;
   localparam int CNT_W     = 12;
   localparam int MAX_BURST = 256;
   localparam int CH_W      = 7;
`ifdef US_SCHED_HEADER_EN
   localparam int HDR_WORDS = 1;
`else
   localparam int HDR_WORDS = 0;
`endif

   logic                     sys_clk = 1'b0;
   logic                     rst = 1'b1;
   logic                     period_pulse = 1'b0;
   logic                     prog_full = 1'b0;
   logic [CH_NUM-1:0]        rd_en;
   logic [CH_NUM*DATA_W-1:0] ch_dout;
   logic [CH_NUM-1:0]        ch_empty;
   logic [CH_NUM*CNT_W-1:0]  ch_count;
   logic                     flow_vld;
   logic [DATA_W-1:0]        flow_data;
   logic [CH_W-1:0]          flow_ch_id;
   logic                     busy;
   logic                     overrun;

   always #5 sys_clk = ~sys_clk;

   us_flow_scheduler dut (
      .sys_clk_i        (sys_clk),
      .rst_i            (rst),
      .period_pulse_i   (period_pulse),
      .ch_rd_en_o       (rd_en),
      .ch_dout_i        (ch_dout),
      .ch_empty_i       (ch_empty),
      .ch_cache_count_i (ch_count),
      .flow_prog_full_i (prog_full),
      .flow_vld_o       (flow_vld),
      .flow_data_o      (flow_data),
      .flow_ch_id_o     (flow_ch_id),
      .busy_o           (busy),
      .overrun_o        (overrun)
   );

   typedef struct {
      logic [DATA_W-1:0] data;
      int                id;
   } exp_t;

   exp_t              exp_q[$];
   logic [DATA_W-1:0] fifo [CH_NUM][$];
   int checks = 0;
   int errors = 0;
   int words_seen = 0;
   int ovr_seen = 0;
   int serial = 0;
   int inj_ch = 0;
   int inj_n = 0;
   int inj_seq = 0;

   task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h", nm, act, req);
      end
   endtask

   // Channel FIFO models: read latency 1, flags registered after each edge.
   task automatic fifo_proc();
      logic [CH_NUM-1:0] re;
      logic pf;
      int seen = 0;
      forever begin
         @(posedge sys_clk);
         re = rd_en;
         pf = prog_full;
         #1;
         if (pf) chk("rd_en_while_prog_full", DATA_W'(re), '0);
         if (re != '0) chk("rd_en_onehot", DATA_W'($countones(re)), DATA_W'(1));
         for (int c = 0; c < CH_NUM; c++) begin
            if (re[c]) begin
               if (fifo[c].size() == 0) chk("fifo_underflow", DATA_W'(c), DATA_W'(-1));
               else ch_dout[c*DATA_W +: DATA_W] = fifo[c].pop_front();
            end
         end
         if (inj_seq != seen) begin
            for (int k = 0; k < inj_n; k++) begin
               fifo[inj_ch].push_back({8'(inj_ch), 24'(serial), $urandom, $urandom, $urandom});
               serial++;
            end
            seen = inj_seq;
         end
         for (int c = 0; c < CH_NUM; c++) begin
            ch_empty[c] = (fifo[c].size() == 0);
            ch_count[c*CNT_W +: CNT_W] = CNT_W'(fifo[c].size());
         end
      end
   endtask

   // Flow monitor: every valid word must match the head of the scoreboard.
   task automatic mon_proc();
      exp_t e;
      forever begin
         @(negedge sys_clk);
         if (overrun) ovr_seen++;
         if (flow_vld) begin
            words_seen++;
            if (exp_q.size() == 0) chk("unexpected_flow_word", flow_data, '0);
            else begin
               e = exp_q.pop_front();
               chk("flow_data", flow_data, e.data);
               chk("flow_ch_id", DATA_W'(flow_ch_id), DATA_W'(e.id));
            end
         end
      end
   endtask

   // Reference sweep: each channel in order, first min(count, MAX_BURST) words.
   task automatic build_expected();
      exp_t e;
      int n;
      for (int c = 0; c < CH_NUM; c++) begin
         n = (fifo[c].size() > MAX_BURST) ? MAX_BURST : fifo[c].size();
         if (n > 0) begin
`ifdef US_SCHED_HEADER_EN
            e.data = {16'hA55A, 16'(c), 16'(n), 80'h0};
            e.id   = c;
            exp_q.push_back(e);
`endif
            for (int k = 0; k < n; k++) begin
               e.data = fifo[c][k];
               e.id   = c;
               exp_q.push_back(e);
            end
         end
      end
   endtask

   task automatic load(input int ch, input int n);
      @(negedge sys_clk);
      inj_ch = ch;
      inj_n  = n;
      inj_seq++;
      @(negedge sys_clk);
   endtask

   task automatic start_sweep();
      @(negedge sys_clk);
      build_expected();
      period_pulse = 1'b1;
      @(negedge sys_clk);
      period_pulse = 1'b0;
   endtask

   task automatic wait_idle(input bit rand_pf);
      int n = 0;
      repeat (2) @(negedge sys_clk);
      while (busy && n < 20000) begin
         @(negedge sys_clk);
         if (rand_pf) prog_full = ($urandom_range(0, 3) == 0);
         n++;
      end
      prog_full = 1'b0;
      chk("sweep_completes", DATA_W'(busy), '0);
      repeat (4) @(negedge sys_clk);
      chk("scoreboard_drained", DATA_W'(exp_q.size()), '0);
   endtask

   task automatic wait_rd(input int ch);
      int n = 0;
      while (!rd_en[ch] && n < 2000) begin
         @(negedge sys_clk);
         n++;
      end
      chk("rd_en_seen", DATA_W'(rd_en[ch]), DATA_W'(1));
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_flow_vld"}, DATA_W'(flow_vld), '0);
      chk({tag, "_flow_data"}, flow_data, '0);
      chk({tag, "_flow_ch_id"}, DATA_W'(flow_ch_id), '0);
      chk({tag, "_busy"}, DATA_W'(busy), '0);
      chk({tag, "_overrun"}, DATA_W'(overrun), '0);
      chk({tag, "_rd_en"}, DATA_W'(rd_en), '0);
   endtask

   initial begin
      int w0;
      int o0;
      int nv;
      int t;
      ch_dout  = '0;
      ch_empty = '1;
      ch_count = '0;
      fork
         fifo_proc();
         mon_proc();
      join_none

      // Reset state
      repeat (3) @(posedge sys_clk);
      #1 chk_outputs_zero("reset");
      @(negedge sys_clk);
      rst = 1'b0;

      // ch0 x3 then ch5 x2, sweep ends after the last channel is skipped
      load(0, 3);
      load(5, 2);
      w0 = words_seen;
      start_sweep();
      wait_idle(1'b0);
      chk("t1_word_count", DATA_W'(words_seen - w0), DATA_W'(5 + 2 * HDR_WORDS));

      // Single channel 1 burst of 4 (header first when enabled)
      load(1, 4);
      w0 = words_seen;
      start_sweep();
      wait_idle(1'b0);
      chk("t6_word_count", DATA_W'(words_seen - w0), DATA_W'(4 + HDR_WORDS));

      // Burst cap: 300 words on ch7 -> 256 now, 44 left for the next period
      load(7, 300);
      w0 = words_seen;
      start_sweep();
      wait_idle(1'b0);
      chk("t2_word_count", DATA_W'(words_seen - w0), DATA_W'(256 + HDR_WORDS));
      chk("t2_ch7_leftover", DATA_W'(fifo[7].size()), DATA_W'(44));
      w0 = words_seen;
      start_sweep();
      wait_idle(1'b0);
      chk("t2_second_period", DATA_W'(words_seen - w0), DATA_W'(44 + HDR_WORDS));

      // prog_full held for 10 cycles in the middle of a ch2 burst
      load(2, 8);
      w0 = words_seen;
      start_sweep();
      wait_rd(2);
      repeat (2) @(negedge sys_clk);
      prog_full = 1'b1;
      repeat (10) @(negedge sys_clk);
      prog_full = 1'b0;
      wait_idle(1'b0);
      chk("t3_word_count", DATA_W'(words_seen - w0), DATA_W'(8 + HDR_WORDS));

      // Period tick during DRAIN: one overrun pulse, no extra sweep
      load(3, 20);
      w0 = words_seen;
      o0 = ovr_seen;
      start_sweep();
      wait_rd(3);
      period_pulse = 1'b1;
      @(negedge sys_clk);
      period_pulse = 1'b0;
      wait_idle(1'b0);
      chk("t4_overrun_pulses", DATA_W'(ovr_seen - o0), DATA_W'(1));
      chk("t4_word_count", DATA_W'(words_seen - w0), DATA_W'(20 + HDR_WORDS));
      repeat (30) @(negedge sys_clk);
      chk("t4_no_second_sweep", DATA_W'(busy), '0);

      // Reset at the 3rd flow word of a 10-word burst
      load(4, 10);
      start_sweep();
      nv = 0;
      t = 0;
      while (nv < 3 && t < 2000) begin
         @(negedge sys_clk);
         if (flow_vld) nv++;
         t++;
      end
      chk("t5_third_word_seen", DATA_W'(nv), DATA_W'(3));
      rst = 1'b1;
      @(posedge sys_clk);
      #1 chk_outputs_zero("t5_after_reset");
      exp_q.delete();
      @(negedge sys_clk);
      rst = 1'b0;
      repeat (20) @(negedge sys_clk);
      chk("t5_idle_after_reset", DATA_W'(busy), '0);

      // Reset and period tick together: reset wins
      @(negedge sys_clk);
      rst = 1'b1;
      period_pulse = 1'b1;
      @(posedge sys_clk);
      #1 chk("rst_vs_pulse_busy", DATA_W'(busy), '0);
      @(negedge sys_clk);
      rst = 1'b0;
      period_pulse = 1'b0;
      @(posedge sys_clk);
      #1 chk("rst_vs_pulse_stays_idle", DATA_W'(busy), '0);

      // Drain leftovers, then randomized periods with random backpressure
      start_sweep();
      wait_idle(1'b1);
      for (int r = 0; r < 6; r++) begin
         int k;
         k = $urandom_range(1, 6);
         for (int j = 0; j < k; j++) load($urandom_range(0, CH_NUM - 1), $urandom_range(0, 60));
         if (r == 3) load($urandom_range(0, CH_NUM - 1), $urandom_range(260, 400));
         start_sweep();
         wait_idle(1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
